// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller for an external 8-bit ALU: registers operands, waits a settle time, captures the result.
// Optional macro ALU_ISSUE_PIPE_EN lets a new request be accepted in the same edge the previous result drains.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int SHIFT_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [2:0] in_sel,
    input  logic       in_shift,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    output logic       alu_shift,
    input  logic [7:0] alu_o,
    input  logic       alu_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_cout,
    output logic       out_zero,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SHIFT_LD  = 4'(SHIFT_CYCLES - 1);
    localparam logic [2:0] SEL_SHIFT = 3'b011;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0] alu_sel_q, alu_sel_d;
    logic       alu_shift_q, alu_shift_d;
    logic [7:0] res_q, res_d;
    logic       cout_q, cout_d, zero_q, zero_d;
    logic       accept;

`ifdef ALU_ISSUE_PIPE_EN
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        alu_shift_d = alu_shift_q;
        res_d       = res_q;
        cout_d      = cout_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = alu_o;
                    cout_d  = alu_cout;
                    zero_d  = (alu_o == 8'h00);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the drain transition so a pipelined accept lands in WAIT.
        if (accept) begin
            alu_a_d     = in_a;
            alu_b_d     = in_b;
            alu_sel_d   = in_sel;
            alu_shift_d = in_shift;
            cnt_d       = (in_sel == SEL_SHIFT) ? SHIFT_LD : SETTLE_LD;
            state_d     = WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_sel_q   <= 3'b000;
            alu_shift_q <= 1'b0;
            res_q       <= 8'h00;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_shift_q <= alu_shift_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign alu_shift  = alu_shift_q;
    assign out_result = res_q;
    assign out_cout   = cout_q;
    assign out_zero   = zero_q;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 8-bit ALU attached; SHIFT_CYCLES=3.
module tb_alu_issue_ctrl;

    localparam int SETTLE = 1;
    localparam int SHIFT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_a = 8'h00, in_b = 8'h00;
    logic [2:0] in_sel = 3'b000;
    logic       in_shift = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic       alu_shift;
    logic [7:0] alu_o;
    logic       alu_cout;
    logic       out_valid, out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_cout, out_zero, busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .SHIFT_CYCLES(SHIFT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_shift(in_shift),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shift(alu_shift),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout), .out_zero(out_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, result}
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel, input logic sh);
        logic [15:0] p;
        case (sel)
            3'b000: ref_alu = {1'b0, a} + {1'b0, b};
            3'b001: ref_alu = {1'b0, a} - {1'b0, b};
            3'b010: begin p = a * b; ref_alu = {1'b0, p[7:0]}; end
            3'b011: ref_alu = {1'b0, sh ? (a >> 1) : (a << 1)};
            3'b100: ref_alu = {1'b0, a | b};
            3'b101: ref_alu = {1'b0, ~a};
            3'b110: ref_alu = {1'b0, a ^ b};
            default: ref_alu = {1'b0, ~(a & b)};
        endcase
    endfunction

    always_comb {alu_cout, alu_o} = ref_alu(alu_a, alu_b, alu_sel, alu_shift);

    function automatic int exp_lat(input logic [2:0] sel);
        exp_lat = (sel == 3'b011) ? SHIFT : SETTLE;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; return cycles until out_valid, ALU-drive stability and captured outputs.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                          input logic sh, input bit noise, output int lat, output bit alu_ok,
                          output logic [9:0] got);
        int guard = 0;
        in_valid = 1'b0;
        while (!in_ready && guard < 20) begin step(); guard++; end
        in_a = a; in_b = b; in_sel = sel; in_shift = sh; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        alu_ok = ({alu_a, alu_b, alu_sel, alu_shift} === {a, b, sel, sh});
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = 8'($urandom); in_b = 8'($urandom); in_sel = 3'($urandom);
            end
            step();
            lat++;
            if ({alu_a, alu_b, alu_sel, alu_shift} !== {a, b, sel, sh}) alu_ok = 1'b0;
        end
        in_valid = 1'b0;
        if (guard >= 20) lat = 99;
        got = {out_cout, out_result, out_zero};
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++;
        if ({out_valid, out_result, out_cout, out_zero} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 000", {out_valid, out_result, out_cout, out_zero});
        end
        n_checks++;
        if ({alu_a, alu_b, alu_sel, alu_shift} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_alu: got %h want 00000", {alu_a, alu_b, alu_sel, alu_shift});
        end
        n_checks++;
        if ({busy, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/in_ready got %b want 01", {busy, in_ready});
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat; bit ok; logic [9:0] got;
        run_op(8'h3C, 8'h05, 3'b000, 1'b0, 1'b0, lat, ok, got);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_checks++;
        if (got !== {1'b0, 8'h41, 1'b0}) begin
            n_fail++; $display("FAIL add_result: got %h want %h", got, {1'b0, 8'h41, 1'b0});
        end
        drain();
        run_op(8'hFF, 8'h01, 3'b000, 1'b0, 1'b0, lat, ok, got);
        n_checks++;
        if (got !== {1'b1, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL add_wrap: got %h want %h", got, {1'b1, 8'h00, 1'b1});
        end
        drain();
    endtask

    task automatic test_shift();
        int lat; bit ok; logic [9:0] got;
        run_op(8'h81, 8'h00, 3'b011, 1'b1, 1'b0, lat, ok, got);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL shift_latency: got %0d want 3", lat); end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL shift_alu_hold: alu drive changed, want stable"); end
        n_checks++;
        if (got !== {1'b0, 8'h40, 1'b0}) begin
            n_fail++; $display("FAIL shift_result: got %h want %h", got, {1'b0, 8'h40, 1'b0});
        end
        drain();
    endtask

    task automatic test_hold();
        int lat; bit ok; logic [9:0] got; bit stable = 1'b1;
        run_op(8'h12, 8'h34, 3'b110, 1'b0, 1'b0, lat, ok, got);
        in_valid = 1'b1; in_a = 8'hAA; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({out_valid, out_cout, out_result, out_zero} !== {1'b1, got} ||
                in_ready !== 1'b0 || alu_a !== 8'h12) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL hold_stable: outputs moved, want stable"); end
        n_checks++;
        if (got !== {1'b0, 8'h26, 1'b0}) begin
            n_fail++; $display("FAIL hold_result: got %h want %h", got, {1'b0, 8'h26, 1'b0});
        end
        in_valid = 1'b0;
        drain();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL hold_drain: out_valid/in_ready got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_wait();
        bit quiet = 1'b1;
        in_a = 8'h5A; in_b = 8'h11; in_sel = 3'b011; in_shift = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_result, out_cout, out_zero, alu_a, alu_b, alu_sel, alu_shift} !== 31'h0) begin
            n_fail++; $display("FAIL rstwait_values: got %h want 0",
                {out_valid, out_result, out_cout, out_zero, alu_a, alu_b, alu_sel, alu_shift});
        end
        n_checks++;
        if ({busy, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstwait_ctrl: busy/in_ready got %b want 01", {busy, in_ready});
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL rstwait_quiet: out_valid rose, want 0"); end
    endtask

    task automatic test_back_to_back();
        int lat; bit ok; logic [9:0] got; int guard = 0;
        run_op(8'h10, 8'h20, 3'b000, 1'b0, 1'b0, lat, ok, got);
        in_a = 8'h02; in_b = 8'h07; in_sel = 3'b000; in_shift = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
`ifdef ALU_ISSUE_PIPE_EN
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if ({out_valid, busy, alu_b} !== {2'b01, 8'h07}) begin
            n_fail++; $display("FAIL b2b_pipe: got %h want %h", {out_valid, busy, alu_b}, {2'b01, 8'h07});
        end
`else
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got %b want 0", in_ready); end
        step();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, alu_b} !== {2'b01, 8'h20}) begin
            n_fail++; $display("FAIL b2b_drain: got %h want %h", {out_valid, in_ready, alu_b}, {2'b01, 8'h20});
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({busy, alu_b} !== {1'b1, 8'h07}) begin
            n_fail++; $display("FAIL b2b_accept: got %h want %h", {busy, alu_b}, {1'b1, 8'h07});
        end
`endif
        while (out_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        n_checks++;
        if ({out_valid, out_cout, out_result} !== {2'b10, 8'h09}) begin
            n_fail++; $display("FAIL b2b_result: got %h want %h", {out_valid, out_cout, out_result}, {2'b10, 8'h09});
        end
        drain();
    endtask

    task automatic test_random();
        int lat; bit ok; logic [9:0] got; logic [8:0] e;
        logic [7:0] a, b; logic [2:0] sel; logic sh;
        for (int i = 0; i < 25; i++) begin
            a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom); sh = 1'($urandom);
            if (i < 3) b = 8'(a);
            e = ref_alu(a, b, sel, sh);
            run_op(a, b, sel, sh, 1'b1, lat, ok, got);
            n_checks++;
            if (lat !== exp_lat(sel) || !ok) begin
                n_fail++; $display("FAIL rand_timing[%0d]: lat %0d alu_ok %0b want lat %0d alu_ok 1",
                                   i, lat, ok, exp_lat(sel));
            end
            n_checks++;
            if (got !== {e, (e[7:0] == 8'h00)}) begin
                n_fail++; $display("FAIL rand_result[%0d]: sel %0d got %h want %h", i, sel, got,
                                   {e, (e[7:0] == 8'h00)});
            end
            repeat ($urandom_range(0, 3)) step();
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_hold();
        test_reset_wait();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles from issue to capture for every non-shift op; legal range 1..15.
REQ-002 SHALL have parameter SHIFT_CYCLES, default 2: cycles from issue to capture for sel=3'b011 (clocked shifter); legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: request handshake.
REQ-006 SHALL have ports in_a input 8, in_b input 8, in_sel input 3 and in_shift input 1: request operands, op code and shift direction.
REQ-007 SHALL have ports alu_a output 8, alu_b output 8, alu_sel output 3 and alu_shift output 1: registered drive to the downstream 8-bit ALU.
REQ-008 SHALL have ports alu_o input 8 and alu_cout input 1: ALU result and carry.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-010 SHALL have ports out_result output 8, out_cout output 1 and out_zero output 1: captured result, carry, and zero flag.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Op encoding SHALL be 000 add, 001 sub, 010 mul, 011 shift, 100 or, 101 not, 110 xor, 111 nand; the block passes sel through and decodes only 011.
REQ-013 FSM states SHALL be IDLE, WAIT and DONE; in_ready SHALL be 1 only in IDLE (see REQ-025).
REQ-014 On an edge with in_valid and in_ready both 1 (accept): register in_a/in_b/in_sel/in_shift onto alu_*, load a 4-bit counter with N-1, and go to WAIT; N = SHIFT_CYCLES if in_sel=011, else SETTLE_CYCLES.
REQ-015 In WAIT, counter nonzero: decrement and stay in WAIT.
REQ-016 In WAIT, counter zero: capture alu_o into out_result and alu_cout into out_cout; set out_zero = (alu_o == 0); set out_valid = 1; go to DONE.
REQ-017 Latency: accept at edge T SHALL make out_valid high after edge T+N, and never earlier.
REQ-018 alu_* outputs SHALL hold the last accepted request, unchanged through WAIT and DONE until the next accept.
REQ-019 In DONE, out_ready=1: clear out_valid at that edge and go to IDLE.
REQ-020 In DONE, out_ready=0: out_valid, out_result, out_cout and out_zero SHALL remain stable.
REQ-021 in_valid outside an accept SHALL be ignored; no request is queued or lost-and-reported.
REQ-022 Captured flags SHALL be taken as driven by the ALU, with no width extension; carry is meaningful only for add/sub, and is captured regardless of op.

Reset
REQ-023 rst=1 at an edge SHALL set state IDLE, counter 0, out_valid 0, out_result 0x00, out_cout 0, out_zero 0, alu_a 0x00, alu_b 0x00, alu_sel 000, alu_shift 0; busy=0 and in_ready=1 from the next cycle.
REQ-024 rst SHALL take priority over every handshake; reset in WAIT or DONE abandons the operation and raises no out_valid for it.

Configuration
REQ-025 Macro ALU_ISSUE_PIPE_EN defined: in_ready SHALL also be 1 in DONE while out_ready=1; a simultaneous drain and accept at one edge SHALL clear the old result handshake and enter WAIT with the new request (out_valid low for at least one cycle).
REQ-026 Macro ALU_ISSUE_PIPE_EN undefined: in_ready SHALL be 1 only in IDLE; back-to-back throughput is at most one op per N+2 cycles.

Verification
REQ-027 Bench ALU model, defaults: in_a=0x3C, in_b=0x05, in_sel=000 accepted at edge T -> out_valid high after edge T+1; out_result=0x41, out_cout=0, out_zero=0.
REQ-028 in_a=0xFF, in_b=0x01, in_sel=000 -> out_result=0x00, out_cout=1, out_zero=1.
REQ-029 in_sel=011, SHIFT_CYCLES=3, accept at T -> out_valid low through edge T+2, high after edge T+3; alu_sel=011 stable throughout.
REQ-030 DONE with out_ready=0 for 5 cycles while in_valid=1 and in_a=0xAA -> outputs stable, in_ready=0, alu_a unchanged; out_ready=1 -> out_valid low and in_ready=1 next cycle.
REQ-031 rst=1 for one cycle during WAIT -> out_valid never rises for that op; all outputs at reset values; in_ready=1 on the next cycle.
REQ-032 ALU_ISSUE_PIPE_EN defined, DONE with out_ready=1 and in_valid=1 (in_b=0x07) -> both handshakes at one edge; alu_b=0x07; state WAIT.
